// File: rtl/dac_update_scheduler_pkg.sv
// Shared types and constants for the DAC update scheduler: FSM encoding, code width, midscale, channel tags.
package dac_sched_pkg;

  localparam int DATA_W_DEF = 12;
  localparam logic [DATA_W_DEF-1:0] MIDSCALE = 12'h800;

  localparam logic CHAN_A = 1'b0;
  localparam logic CHAN_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_A,
    WAIT_B
  } state_t;

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Requester and DAC-driver signals of the scheduler; slave = scheduler side, master = requesters/driver side.
interface dac_update_scheduler_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 12
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_chan;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       V_A;
  logic [DATA_W-1:0]       V_B;
  logic                    synchro;
  logic                    dacNumber;
  logic                    busy;
  logic                    timeout_err;

  modport slave (
    input  req, req_chan, req_data, dacNumber,
    output ack, V_A, V_B, synchro, busy, timeout_err
  );

  modport master (
    output req, req_chan, req_data, dacNumber,
    input  ack, V_A, V_B, synchro, busy, timeout_err
  );

endinterface

// File: rtl/dac_update_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or after ptr, cyclically.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          vld
);

  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!vld && req[k]) begin
        vld      = 1'b1;
        grant[k] = 1'b1;
        idx      = PW'(k);
      end
    end
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// Shares the dual-channel DAC driver between requesters: RR-accepts updates into shadows, launches A/B frames.
// Optional SLEW_LIMIT_EN: each launch moves V_A/V_B toward the shadow by at most MAX_STEP.
module dac_update_scheduler
  import dac_sched_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_STEP    = 64
) (
  input logic                   CLK_50M,
  input logic                   RST_N,
  dac_update_scheduler_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [DATA_W-1:0] MID = (DATA_W == DATA_W_DEF) ? DATA_W'(MIDSCALE)
                                                             : {1'b1, {(DATA_W-1){1'b0}}};

  generate
    if (N_REQ < 1 || N_REQ > 8 || MAX_STEP < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("dac_update_scheduler: unsupported parameter set");
    end
  endgenerate

  state_t            state, state_nx;
  logic [PW-1:0]     rr_ptr;
  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic              gnt_chan;
  logic [DATA_W-1:0] gnt_data;
  logic              wr_a, wr_b;
  logic [DATA_W-1:0] shadow_a, shadow_b;
  logic [DATA_W-1:0] va, vb, va_nx, vb_nx;
  logic              pend_a, pend_b, keep_a, keep_b;
  logic              dn_p0, dn_p1, dn_p2;
  logic              dn_rise, dn_fall;
  logic [TW-1:0]     timer;
  logic              tmo;
  logic              launch, done, timer_clr, err_set;
  logic              busy, timeout_err;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .vld   (gnt_vld)
  );

  assign bus.ack  = gnt & {N_REQ{RST_N}};
  assign gnt_chan = bus.req_chan[gnt_idx];
  assign gnt_data = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign wr_a     = gnt_vld && (gnt_chan == CHAN_A);
  assign wr_b     = gnt_vld && (gnt_chan == CHAN_B);

`ifdef SLEW_LIMIT_EN
  function automatic logic [DATA_W-1:0] slew_step(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] tgt);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (int'(diff) > MAX_STEP)       return cur + DATA_W'(MAX_STEP);
    else if (int'(diff) < -MAX_STEP) return cur - DATA_W'(MAX_STEP);
    else                             return tgt;
  endfunction

  assign va_nx  = slew_step(va, shadow_a);
  assign vb_nx  = slew_step(vb, shadow_b);
  assign keep_a = (va_nx != shadow_a);
  assign keep_b = (vb_nx != shadow_b);
`else
  assign va_nx  = shadow_a;
  assign vb_nx  = shadow_b;
  assign keep_a = 1'b0;
  assign keep_b = 1'b0;
`endif

  assign dn_rise = dn_p1 & ~dn_p2;
  assign dn_fall = ~dn_p1 & dn_p2;
  assign tmo     = (timer == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nx  = state;
    launch    = 1'b0;
    done      = 1'b0;
    timer_clr = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:   if (pend_a || pend_b) state_nx = LAUNCH;
      LAUNCH: begin
        launch    = 1'b1;
        timer_clr = 1'b1;
        state_nx  = WAIT_A;
      end
      WAIT_A: begin
        if (tmo) begin
          state_nx = IDLE;
          done     = 1'b1;
          err_set  = 1'b1;
        end else if (dn_rise) begin
          state_nx  = WAIT_B;
          timer_clr = 1'b1;
        end
      end
      WAIT_B: begin
        if (tmo) begin
          state_nx = IDLE;
          done     = 1'b1;
          err_set  = 1'b1;
        end else if (dn_fall) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // control: arbitration pointer, pend flags, synchroniser, timer, status
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      rr_ptr      <= '0;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      dn_p0       <= 1'b0;
      dn_p1       <= 1'b0;
      dn_p2       <= 1'b0;
      timer       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dn_p0 <= bus.dacNumber;
      dn_p1 <= dn_p0;
      dn_p2 <= dn_p1;
      if (gnt_vld) rr_ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      // a grant on the launch edge re-arms pend so the fresh code goes out next frame
      if (launch) begin
        pend_a <= keep_a;
        pend_b <= keep_b;
      end
      if (wr_a) pend_a <= 1'b1;
      if (wr_b) pend_b <= 1'b1;
      if (timer_clr || state == IDLE) timer <= '0;
      else                            timer <= timer + 1'b1;
      if (launch)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (err_set) timeout_err <= 1'b1;
    end
  end

  // data: shadows and output codes
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      shadow_a <= MID;
      shadow_b <= MID;
      va       <= MID;
      vb       <= MID;
    end else begin
      if (wr_a) shadow_a <= gnt_data;
      if (wr_b) shadow_b <= gnt_data;
      if (launch) begin
        va <= va_nx;
        vb <= vb_nx;
      end
    end
  end

  assign bus.V_A         = va;
  assign bus.V_B         = vb;
  assign bus.synchro     = launch;
  assign bus.busy        = busy;
  assign bus.timeout_err = timeout_err;

endmodule
